spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Command-decoding single-port memory that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit received word (rx_data, rx_valid).
- Returns read bytes (tx_data, tx_valid) for the slave to shift out on MISO.
- Adds separate write/read address pointers with optional auto-increment for burst access, plus a protocol-error pulse for out-of-order commands.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address pointer width (1..8); uses rx_data[ADDR_SIZE-1:0], upper payload bits ignored.
- AUTO_INC, 1, 1 = post-increment the pointer after each data access; 0 = pointer holds.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_data  input  10  [9:8] command, [7:0] payload
- rx_valid  input  1  rx_data valid this cycle; one command per asserted cycle
- tx_data  output  8  read byte to SPI slave
- tx_valid  output  1  one-cycle pulse, tx_data valid
- cmd_err  output  1  one-cycle pulse, rejected command

Behaviour:
- Reset (rst=1 at a rising edge, has priority over rx_valid):
  - wr_ptr=0, rd_ptr=0, wr_armed=0, rd_armed=0.
  - tx_data=8'h00, tx_valid=0, cmd_err=0.
  - Memory array is not cleared.
- Commands are decoded only when rx_valid=1; rx_data is ignored otherwise.
- 2'b00 WR_ADDR: wr_ptr <= payload, wr_armed <= 1. No output activity.
- 2'b01 WR_DATA:
  - If wr_armed: mem[wr_ptr] <= payload.
  - If AUTO_INC: wr_ptr <= wr_ptr+1, wrapping MEM_DEPTH-1 -> 0.
  - If !wr_armed: no write, cmd_err=1 for the next cycle.
- 2'b10 RD_ADDR: rd_ptr <= payload, rd_armed <= 1. No output activity.
- 2'b11 RD_DATA:
  - If rd_armed: tx_data <= mem[rd_ptr], tx_valid=1 for exactly one cycle.
  - Latency: command accepted at edge N; tx_valid high between edges N and N+1, i.e. registered one cycle after the rx_valid cycle.
  - If AUTO_INC: rd_ptr <= rd_ptr+1 with the same wrap rule.
  - If !rd_armed: tx_valid stays 0, tx_data holds, cmd_err=1 for one cycle.
- tx_data holds its last read value until the next successful RD_DATA. It never returns to 0 except on reset.
- Back-to-back commands (rx_valid high on consecutive cycles) are all accepted. No stall and no backpressure.
- Read-after-write: WR_DATA at edge N followed by RD_DATA to the same address at edge N+1 returns the newly written byte.
- Write and read pointers are independent. WR_ADDR does not arm reads, and vice versa.
- Arming persists until reset. Re-issuing an address command overwrites the pointer.
- Reset mid-burst: the pointer and arm flags clear; the memory content written before reset is retained.
- Internal state machine, tracking per-pointer arm state:
  - IDLE (neither armed), WR_RDY, RD_RDY, BOTH.
  - Transitions occur only on address commands or reset.
  - Data commands never change the state.
- cmd_err and tx_valid are never asserted in the same cycle, since only one command is accepted per cycle.

Test Plan:
- Reset, then RD_DATA (rx_data=10'h300) -> tx_valid stays 0, cmd_err=1 for one cycle. Then WR_DATA 10'h1AA -> cmd_err=1, memory unchanged.
- WR_ADDR 10'h010, WR_DATA 10'h1A5, RD_ADDR 10'h210, RD_DATA 10'h300 -> tx_valid one cycle after the RD_DATA cycle, tx_data=8'hA5.
- AUTO_INC=1, burst: WR_ADDR 10'h0FE, then WR_DATA 11, 22, 33 (payloads 8'h11/8'h22/8'h33) -> mem[FE]=11, mem[FF]=22, mem[00]=33 (wrap). RD_ADDR 10'h2FE plus three back-to-back RD_DATA -> tx_data sequence 11, 22, 33 on consecutive cycles.
- WR_DATA to address 5 (value 8'h7E) at cycle N, then RD_ADDR 5 and RD_DATA at N+1/N+2 -> tx_data=8'h7E. tx_data holds 8'h7E after the tx_valid pulse.
- rst asserted together with rx_valid=1, rx_data=10'h1FF after arming at address 3 -> no write. Pointers 0, both arm flags 0. Subsequent RD_DATA gives cmd_err=1. RD_ADDR 3, RD_DATA returns the pre-reset content of mem[3].
- AUTO_INC=0: WR_ADDR 10'h020, WR_DATA 8'h01 then 8'h02 -> mem[0x20]=8'h02, mem[0x21] untouched.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoding byte memory behind the SPI slave.
// Decodes 10-bit words {cmd[1:0], payload[7:0]}. Separate write and read
// pointers must be armed by an address command before data commands are
// honoured. Each pointer optionally post-increments after every access.
// MEM_DEPTH must equal 2**ADDR_SIZE, so pointer arithmetic wraps naturally.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_cmd_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WR_RDY = 2'b01,
        RD_RDY = 2'b10,
        BOTH   = 2'b11
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_wr_armed;
    logic                   w_rd_armed;

    logic [ADDR_SIZE-1:0]   r_wr_ptr;
    logic [ADDR_SIZE-1:0]   r_rd_ptr;
    logic [7:0]             r_mem [MEM_DEPTH];
    logic [7:0]             r_tx_data;
    logic                   r_tx_valid;
    logic                   r_cmd_err;

    logic                   w_accept;
    logic [1:0]             w_cmd;
    logic [7:0]             w_payload;
    logic [ADDR_SIZE-1:0]   w_payload_addr;
    logic                   w_is_wr_addr;
    logic                   w_is_wr_data;
    logic                   w_is_rd_addr;
    logic                   w_is_rd_data;
    logic                   w_do_write;
    logic                   w_do_read;
    logic                   w_reject;

    // Reset wins over a simultaneous command, so no command is accepted in a reset cycle
    assign w_accept       = i_rx_valid && !i_rst;
    assign w_cmd          = i_rx_data[9:8];
    assign w_payload      = i_rx_data[7:0];
    assign w_payload_addr = w_payload[ADDR_SIZE-1:0];

    assign w_is_wr_addr = w_accept && (w_cmd == CMD_WR_ADDR);
    assign w_is_wr_data = w_accept && (w_cmd == CMD_WR_DATA);
    assign w_is_rd_addr = w_accept && (w_cmd == CMD_RD_ADDR);
    assign w_is_rd_data = w_accept && (w_cmd == CMD_RD_DATA);

    assign w_do_write = w_is_wr_data && w_wr_armed;
    assign w_do_read  = w_is_rd_data && w_rd_armed;
    assign w_reject   = (w_is_wr_data && !w_wr_armed) || (w_is_rd_data && !w_rd_armed);

    // Arm-state register: cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next arm state: only address commands move it, data commands never do
    always_comb begin
        w_next_state = r_state;
        if (w_is_wr_addr) begin
            case (r_state)
                IDLE:    w_next_state = WR_RDY;
                RD_RDY:  w_next_state = BOTH;
                default: w_next_state = r_state;
            endcase
        end else if (w_is_rd_addr) begin
            case (r_state)
                IDLE:    w_next_state = RD_RDY;
                WR_RDY:  w_next_state = BOTH;
                default: w_next_state = r_state;
            endcase
        end
    end

    // Decode the arm state into per-pointer enables
    always_comb begin
        w_wr_armed = 1'b0;
        w_rd_armed = 1'b0;
        case (r_state)
            WR_RDY:  w_wr_armed = 1'b1;
            RD_RDY:  w_rd_armed = 1'b1;
            BOTH: begin
                w_wr_armed = 1'b1;
                w_rd_armed = 1'b1;
            end
            default: begin
                w_wr_armed = 1'b0;
                w_rd_armed = 1'b0;
            end
        endcase
    end

    // Write pointer: loaded by WR_ADDR, optionally bumped after each accepted write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
        end else if (w_is_wr_addr) begin
            r_wr_ptr <= w_payload_addr;
        end else if (w_do_write && (AUTO_INC != 0)) begin
            r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
        end
    end

    // Read pointer: loaded by RD_ADDR, optionally bumped after each accepted read
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
        end else if (w_is_rd_addr) begin
            r_rd_ptr <= w_payload_addr;
        end else if (w_do_read && (AUTO_INC != 0)) begin
            r_rd_ptr <= r_rd_ptr + ADDR_SIZE'(1);
        end
    end

    // Memory array has no reset so contents survive a mid-burst reset
    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= w_payload;
        end
    end

    // Registered responses; tx_data holds its last read value between reads
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_tx_valid <= w_do_read;
            r_cmd_err  <= w_reject;
            if (w_do_read) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: scoreboard bench for spi_ram_ctrl.
// Unit 0 runs with AUTO_INC=1, unit 1 with AUTO_INC=0. Every driven cycle
// pushes the expected response of that cycle; a monitor pops it one cycle
// later and compares tx_valid, cmd_err and tx_data.
module tb_spi_ram_ctrl;

    typedef struct {
        int         stamp;
        logic       txValid;
        logic       cmdErr;
        logic [7:0] txData;
    } exp_t;

    logic       clock;
    logic       rst0, rst1;
    logic       valid0, valid1;
    logic [9:0] rxData0, rxData1;
    logic [7:0] txData0, txData1;
    logic       txValid0, txValid1;
    logic       cmdErr0, cmdErr1;

    int vectorCount;
    int missCount;
    int cycleCount;

    exp_t sbQ0[$];
    exp_t sbQ1[$];

    logic [7:0] mMem [2][256];
    int         wrPtr [2];
    int         rdPtr [2];
    bit         wrArm [2];
    bit         rdArm [2];
    logic [7:0] lastTx [2];
    bit         autoInc [2];

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut0 (
        .i_clk      (clock),
        .i_rst      (rst0),
        .i_rx_data  (rxData0),
        .i_rx_valid (valid0),
        .o_tx_data  (txData0),
        .o_tx_valid (txValid0),
        .o_cmd_err  (cmdErr0)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut1 (
        .i_clk      (clock),
        .i_rst      (rst1),
        .i_rx_data  (rxData1),
        .i_rx_valid (valid1),
        .o_tx_data  (txData1),
        .o_tx_valid (txValid1),
        .o_cmd_err  (cmdErr1)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle stamp used to tell which queued entries the DUT has already answered
    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic compareEntry(input string unitName, input exp_t e, input logic v,
                                input logic err, input logic [7:0] d);
        checkOutput($sformatf("%s_txValid@%0d", unitName, e.stamp), {7'b0, v}, {7'b0, e.txValid});
        checkOutput($sformatf("%s_cmdErr@%0d", unitName, e.stamp), {7'b0, err}, {7'b0, e.cmdErr});
        checkOutput($sformatf("%s_txData@%0d", unitName, e.stamp), d, e.txData);
    endtask

    // Monitor: one cycle after a command was captured, compare its response
    always @(negedge clock) begin
        exp_t e;
        if (sbQ0.size() > 0 && sbQ0[0].stamp < cycleCount) begin
            e = sbQ0.pop_front();
            compareEntry("u0", e, txValid0, cmdErr0, txData0);
        end
        if (sbQ1.size() > 0 && sbQ1[0].stamp < cycleCount) begin
            e = sbQ1.pop_front();
            compareEntry("u1", e, txValid1, cmdErr1, txData1);
        end
    end

    // Drive one cycle to a unit, advance the reference model and queue the expected response
    task automatic applyStimulus(input int unit, input logic rstIn, input logic validIn, input logic [9:0] word);
        exp_t       e;
        logic [7:0] pl;
        @(negedge clock);
        if (unit == 0) begin
            rst0 = rstIn; valid0 = validIn; rxData0 = word;
            rst1 = 1'b0;  valid1 = 1'b0;
        end else begin
            rst1 = rstIn; valid1 = validIn; rxData1 = word;
            rst0 = 1'b0;  valid0 = 1'b0;
        end
        e.stamp   = cycleCount;
        e.txValid = 1'b0;
        e.cmdErr  = 1'b0;
        pl = word[7:0];
        if (rstIn) begin
            wrPtr[unit]  = 0;
            rdPtr[unit]  = 0;
            wrArm[unit]  = 1'b0;
            rdArm[unit]  = 1'b0;
            lastTx[unit] = 8'h00;
        end else if (validIn) begin
            case (word[9:8])
                2'b00: begin
                    wrPtr[unit] = int'(pl);
                    wrArm[unit] = 1'b1;
                end
                2'b01: begin
                    if (wrArm[unit]) begin
                        mMem[unit][wrPtr[unit]] = pl;
                        if (autoInc[unit]) wrPtr[unit] = (wrPtr[unit] + 1) % 256;
                    end else begin
                        e.cmdErr = 1'b1;
                    end
                end
                2'b10: begin
                    rdPtr[unit] = int'(pl);
                    rdArm[unit] = 1'b1;
                end
                default: begin
                    if (rdArm[unit]) begin
                        lastTx[unit] = mMem[unit][rdPtr[unit]];
                        e.txValid = 1'b1;
                        if (autoInc[unit]) rdPtr[unit] = (rdPtr[unit] + 1) % 256;
                    end else begin
                        e.cmdErr = 1'b1;
                    end
                end
            endcase
        end
        e.txData = lastTx[unit];
        if (unit == 0) sbQ0.push_back(e);
        else           sbQ1.push_back(e);
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        cycleCount  = 0;
        autoInc[0]  = 1'b1;
        autoInc[1]  = 1'b0;
        for (int u = 0; u < 2; u++) begin
            wrPtr[u] = 0; rdPtr[u] = 0; wrArm[u] = 1'b0; rdArm[u] = 1'b0; lastTx[u] = 8'h00;
        end
        rst0 = 1'b1; rst1 = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        rxData0 = '0; rxData1 = '0;

        // Reset, then data commands before any arming are rejected
        applyStimulus(0, 1'b1, 1'b0, 10'h000);
        applyStimulus(0, 1'b1, 1'b0, 10'h000);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);
        applyStimulus(0, 1'b0, 1'b1, 10'h1AA);
        applyStimulus(0, 1'b0, 1'b0, 10'h3FF);

        // Basic write then read
        applyStimulus(0, 1'b0, 1'b1, 10'h010);
        applyStimulus(0, 1'b0, 1'b1, 10'h1A5);
        applyStimulus(0, 1'b0, 1'b1, 10'h210);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);

        // Burst write across the wrap point, then back-to-back burst read
        applyStimulus(0, 1'b0, 1'b1, 10'h0FE);
        applyStimulus(0, 1'b0, 1'b1, 10'h111);
        applyStimulus(0, 1'b0, 1'b1, 10'h122);
        applyStimulus(0, 1'b0, 1'b1, 10'h133);
        applyStimulus(0, 1'b0, 1'b1, 10'h2FE);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);
        applyStimulus(0, 1'b0, 1'b0, 10'h000);

        // Write at address 5, readback, and tx_data holding afterwards
        applyStimulus(0, 1'b0, 1'b1, 10'h005);
        applyStimulus(0, 1'b0, 1'b1, 10'h17E);
        applyStimulus(0, 1'b0, 1'b1, 10'h205);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);
        applyStimulus(0, 1'b0, 1'b0, 10'h000);
        applyStimulus(0, 1'b0, 1'b0, 10'h000);
        checkOutput("hold7E_data", txData0, 8'h7E);
        checkOutput("hold7E_valid", {7'b0, txValid0}, 8'h00);

        // Read-after-write on the very next cycle
        applyStimulus(0, 1'b0, 1'b1, 10'h240);
        applyStimulus(0, 1'b0, 1'b1, 10'h040);
        applyStimulus(0, 1'b0, 1'b1, 10'h13C);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);

        // Reset mid-burst with a colliding write command
        applyStimulus(0, 1'b0, 1'b1, 10'h003);
        applyStimulus(0, 1'b0, 1'b1, 10'h199);
        applyStimulus(0, 1'b0, 1'b1, 10'h003);
        applyStimulus(0, 1'b1, 1'b1, 10'h1FF);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);
        applyStimulus(0, 1'b0, 1'b1, 10'h1AA);
        applyStimulus(0, 1'b0, 1'b1, 10'h203);
        applyStimulus(0, 1'b0, 1'b1, 10'h300);
        applyStimulus(0, 1'b0, 1'b0, 10'h000);
        checkOutput("preResetMem3", txData0, 8'h99);

        // AUTO_INC=0 unit: repeated writes stay on one address
        applyStimulus(1, 1'b1, 1'b0, 10'h000);
        applyStimulus(1, 1'b0, 1'b1, 10'h021);
        applyStimulus(1, 1'b0, 1'b1, 10'h15C);
        applyStimulus(1, 1'b0, 1'b1, 10'h020);
        applyStimulus(1, 1'b0, 1'b1, 10'h101);
        applyStimulus(1, 1'b0, 1'b1, 10'h102);
        applyStimulus(1, 1'b0, 1'b1, 10'h220);
        applyStimulus(1, 1'b0, 1'b1, 10'h300);
        applyStimulus(1, 1'b0, 1'b1, 10'h300);
        applyStimulus(1, 1'b0, 1'b1, 10'h221);
        applyStimulus(1, 1'b0, 1'b1, 10'h300);
        applyStimulus(1, 1'b0, 1'b0, 10'h000);
        checkOutput("noInc_mem21", txData1, 8'h5C);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 20 && (sbQ0.size() + sbQ1.size()) > 0; i++) @(negedge clock);
        @(negedge clock);
        checkOutput("drain", 8'(sbQ0.size() + sbQ1.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
